// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider: op codes, FSM states, default width.
package div_unit_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, subtract divisor when it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN+1:0] shifted;
  logic            fits;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    fits     = (shifted >= {2'b00, divisor});
    rem_next = fits ? (shifted[XLEN:0] - {1'b0, divisor}) : shifted[XLEN:0];
    quo_next = {quo[XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: one restoring step per cycle, valid/ready on both sides.
import div_unit_pkg::*;

module div_unit #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ONES     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + ONE;
  endfunction

  // Magnitude of the most negative value is itself, which is right as an unsigned quantity.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? neg(x) : x;
  endfunction

  div_state_t       state, state_next;
  logic [CNT_W-1:0] counter;
  logic [XLEN:0]    rem, rem_next;
  logic [XLEN-1:0]  quo, quo_next, divisor;
  logic             rem_op_q, q_neg_q, r_neg_q;

  logic             accept, is_signed, is_rem, is_special;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN-1:0]  special_res, fix_res;

  assign a_s       = a;
  assign b_s       = b;
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready & ~flush;
  assign is_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign is_rem    = (op == DIV_OP_REM) || (op == DIV_OP_REMU);

  always_comb begin
    is_special  = 1'b0;
    special_res = '0;
    if (b == '0) begin
      is_special  = 1'b1;
      special_res = is_rem ? a : ONES;
    end else if (is_signed && a == MIN_VAL && b == ONES) begin
      is_special  = 1'b1;
      special_res = is_rem ? '0 : MIN_VAL;
    end
  end

  always_comb begin
    fix_res = rem_op_q ? (r_neg_q ? neg(rem[XLEN-1:0]) : rem[XLEN-1:0])
                       : (q_neg_q ? neg(quo) : quo);
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = is_special ? ST_DONE : ST_CALC;
      ST_CALC: if (counter == CNT_LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Control-visible registers: counter and result return to zero on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter <= '0;
      result  <= '0;
    end else if (!flush) begin
      if (state == ST_IDLE && accept) begin
        counter <= '0;
        if (is_special) result <= special_res;
      end else if (state == ST_CALC) begin
        counter <= counter + CNT_ONE;
      end else if (state == ST_FIX) begin
        result <= fix_res;
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept) begin
      rem_op_q <= is_rem;
      q_neg_q  <= is_signed & (a_s[XLEN-1] ^ b_s[XLEN-1]);
      r_neg_q  <= is_signed & a_s[XLEN-1];
      divisor  <= mag(b, is_signed);
      quo      <= mag(a, is_signed);
      rem      <= '0;
    end else if (state == ST_CALC) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  op;
  logic [31:0] a, b, result;

  int n_assert = 0;
  int n_fail   = 0;

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics from plain integer arithmetic (SV / and % truncate toward zero).
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      2'b00:   return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
      2'b01:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      2'b10:   return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic await_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    issue(o, x, y);
    await_result(lat);
    check({tag, "_latency"}, lat, exp_latency(o, x, y));
    check({tag, "_result"}, result, model(o, x, y));
    tick();
    check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int          lat;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; a = '0; b = '0;
    tick(); tick();
    check("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    do_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    do_op("div_by0", 2'b00, 32'd5, 32'd0);
    do_op("remu_by0", 2'b11, 32'd5, 32'd0);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu_min", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div_min_3", 2'b00, 32'h8000_0000, 32'd3);
    do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    check("spot_model_div", model(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);

    // Flush mid-CALC at edge 10
    issue(2'b01, 32'd1000, 32'd3);
    repeat (8) tick();
    check("flush_pre_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_state", {29'd0, busy, out_valid, in_ready}, 32'd1);
    repeat (40) tick();
    check("flush_no_result", {31'd0, out_valid}, 32'd0);

    // Flush together with in_valid in IDLE must not accept
    op = 2'b01; a = 32'd50; b = 32'd5; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {31'd0, busy}, 32'd0);
    do_op("divu_9_3", 2'b01, 32'd9, 32'd3);

    // Backpressure: result held, new requests ignored
    out_ready = 1'b0;
    issue(2'b00, 32'hFFFF_FF00, 32'd7);
    await_result(lat);
    held = result;
    check("bp_result", held, model(2'b00, 32'hFFFF_FF00, 32'd7));
    for (int i = 0; i < 5; i++) begin
      op = 2'b01; a = 32'd77 + i; b = 32'd2; in_valid = 1'b1;
      tick();
      check("bp_hold_result", result, held);
      check("bp_hold_flags", {29'd0, out_valid, in_ready, busy}, 32'h5);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release", {29'd0, out_valid, in_ready, busy}, 32'h2);

    // Reset mid-CALC
    issue(2'b01, 32'd123456, 32'd17);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_flags", {29'd0, out_valid, in_ready, busy}, 32'h2);
    check("rst_mid_result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 28);
      endcase
      if (i % 9 == 4) ra = 32'h8000_0000;
      do_op("rand", ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
